// File: rtl/imem_loader_if.sv
// Host-side word stream plus byte-wide write port of the instruction memory loader.
// Latency/backpressure live in the loader; this only bundles the signals.
interface imem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 7
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  words_written;

  modport master (
    output start, base_addr, word_count, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, words_written
  );

  modport slave (
    input  start, base_addr, word_count, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, words_written
  );
endinterface

// File: rtl/imem_loader.sv
// Splits 32-bit words into four big-endian byte writes (MSB at lowest address).
// 5 cycles per word (1 accept + 4 writes); in_ready only in WAIT_WORD, so the host is stalled during writes.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 7
) (
  input logic          clk,
  input logic          rst_n,
  imem_loader_if.slave bus
);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_WORD = 2'd1;
  localparam logic [1:0] WRITE     = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  words_written;
  logic [31:0]       word;
  logic [1:0]        byte_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr          <= '0;
      remaining     <= '0;
      words_written <= '0;
      word          <= '0;
      byte_idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            words_written <= '0;
            if (bus.word_count != '0) begin
              addr      <= bus.base_addr;
              remaining <= bus.word_count;
              state     <= WAIT_WORD;
            end else begin
              state <= DONE;
            end
          end
        end
        WAIT_WORD: begin
          if (bus.in_valid) begin
            word     <= bus.in_data;
            byte_idx <= 2'd0;
            state    <= WRITE;
          end
        end
        WRITE: begin
          // Address wraps silently at the top of memory.
          addr     <= addr + ADDR_W'(1);
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            remaining     <= remaining - CNT_W'(1);
            words_written <= words_written + CNT_W'(1);
            state         <= (remaining == CNT_W'(1)) ? DONE : WAIT_WORD;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Byte 0 is word[31:24]; low bit index is 8*(3-byte_idx).
  assign bus.mem_wdata     = word[{~byte_idx, 3'b000} +: 8];
  assign bus.mem_addr      = addr;
  assign bus.mem_we        = (state == WRITE);
  assign bus.in_ready      = (state == WAIT_WORD);
  assign bus.busy          = (state == WAIT_WORD) || (state == WRITE);
  assign bus.done          = (state == DONE);
  assign bus.words_written = words_written;
endmodule
